zone_select_ctrl: RTL and testbench

Sequencing controller for the four-quadrant screen selection on the VGA application path. It classifies the current pixel into a quadrant and holds a user-selected zone that is moved with next/prev buttons and locked with ok/cancel. It also produces a per-pixel highlight (blinking while browsing, steady when locked) for the pixel colour mux. It sits between the VGA sync counters/button conditioning and the RGB output stage.

---
 rtl/zone_pkg.sv | 40 ++++
 rtl/zone_select_ctrl_classify.sv | 23 ++
 rtl/zone_select_ctrl.sv | 126 ++++++++++++
 tb/tb_zone_select_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zone_pkg.sv
// Shared types and defaults for the VGA quadrant selection controller.
package zone_pkg;

  typedef enum logic [1:0] {
    ZONE_TR = 2'd0,
    ZONE_BR = 2'd1,
    ZONE_BL = 2'd2,
    ZONE_TL = 2'd3
  } zone_t;

  typedef enum logic {
    BROWSE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int H_SPLIT_DEF      = 464;
  localparam int V_SPLIT_DEF      = 275;
  localparam int BLINK_FRAMES_DEF = 30;

  localparam int BTN_NEXT   = 0;
  localparam int BTN_PREV   = 1;
  localparam int BTN_OK     = 2;
  localparam int BTN_CANCEL = 3;

  function automatic zone_t zone_of(
    input logic right,
    input logic bottom
  );
    zone_t z;
    z = ZONE_TL;
    unique case ({right, bottom})
      2'b10:   z = ZONE_TR;
      2'b11:   z = ZONE_BR;
      2'b01:   z = ZONE_BL;
      default: z = ZONE_TL;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/zone_select_ctrl_classify.sv
// Combinational pixel-coordinate to screen-quadrant map.
import zone_pkg::*;

module zone_classify #(
  parameter int H_SPLIT = H_SPLIT_DEF,
  parameter int V_SPLIT = V_SPLIT_DEF
) (
  input  logic [9:0] horizontal,
  input  logic [9:0] vertical,
  output logic [1:0] zone
);

  localparam logic [9:0] HS = 10'(H_SPLIT);
  localparam logic [9:0] VS = 10'(V_SPLIT);

  logic right;
  logic bottom;

  assign right  = horizontal > HS;
  assign bottom = vertical > VS;
  assign zone   = zone_of(right, bottom);

endmodule

// File: rtl/zone_select_ctrl.sv
// Quadrant selection FSM with button edge detect, frame tick
// and blinking highlight for the RGB colour mux.
import zone_pkg::*;

module zone_select_ctrl #(
  parameter int H_SPLIT      = H_SPLIT_DEF,
  parameter int V_SPLIT      = V_SPLIT_DEF,
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] horizontal,
  input  logic [9:0] vertical,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_ok,
  input  logic       btn_cancel,
  output logic [1:0] pix_zone,
  output logic [1:0] sel_zone,
  output logic       locked,
  output logic       confirm_pulse,
  output logic       highlight
);

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  state_t     state;
  logic [1:0] zone_d;
  logic [3:0] btn;
  logic [3:0] btn_q;
  logic [3:0] ev;
  logic       at0;
  logic       at0_q;
  logic       tick;
  logic [1:0] sel_nxt;
  logic       sel_chg;
  logic [7:0] blink_cnt;
  logic       blink_phase;

  zone_classify #(
    .H_SPLIT(H_SPLIT),
    .V_SPLIT(V_SPLIT)
  ) u_classify (
    .horizontal(horizontal),
    .vertical  (vertical),
    .zone      (zone_d)
  );

  assign btn  = {btn_cancel, btn_ok, btn_prev, btn_next};
  assign ev   = btn & ~btn_q;
  assign at0  = (horizontal == '0) && (vertical == '0);
  assign tick = at0 & ~at0_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q    <= '1;
      at0_q    <= 1'b0;
      pix_zone <= '0;
    end else begin
      btn_q    <= btn;
      at0_q    <= at0;
      pix_zone <= zone_d;
    end
  end

  // ok wins over next/prev; opposing next+prev cancel out
  always_comb begin
    sel_nxt = sel_zone;
    if (state == BROWSE && !ev[BTN_OK]) begin
      unique case (1'b1)
        ev[BTN_NEXT] && !ev[BTN_PREV]: sel_nxt = 2'(sel_zone + 2'd1);
        ev[BTN_PREV] && !ev[BTN_NEXT]: sel_nxt = 2'(sel_zone - 2'd1);
        default:                       sel_nxt = sel_zone;
      endcase
    end
  end

  assign sel_chg = sel_nxt != sel_zone;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= BROWSE;
      sel_zone      <= '0;
      locked        <= 1'b0;
      confirm_pulse <= 1'b0;
    end else begin
      confirm_pulse <= 1'b0;
      sel_zone      <= sel_nxt;
      unique case (state)
        BROWSE: begin
          if (ev[BTN_OK]) begin
            state         <= LOCKED;
            locked        <= 1'b1;
            confirm_pulse <= 1'b1;
          end
        end
        LOCKED: begin
          if (ev[BTN_CANCEL]) begin
            state  <= BROWSE;
            locked <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (sel_chg) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  assign highlight = (pix_zone == sel_zone) & (locked | blink_phase);

endmodule

// File: tb/tb_zone_select_ctrl.sv
// Directed vector table plus randomized run against a reference model.
module tb_zone_select_ctrl;

  localparam int HS = 464;
  localparam int VS = 275;
  localparam int BF = 2;

  logic       clk;
  logic       reset;
  logic [9:0] horizontal;
  logic [9:0] vertical;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_ok;
  logic       btn_cancel;
  logic [1:0] pix_zone;
  logic [1:0] sel_zone;
  logic       locked;
  logic       confirm_pulse;
  logic       highlight;

  zone_select_ctrl #(
    .H_SPLIT(HS),
    .V_SPLIT(VS),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .horizontal   (horizontal),
    .vertical     (vertical),
    .btn_next     (btn_next),
    .btn_prev     (btn_prev),
    .btn_ok       (btn_ok),
    .btn_cancel   (btn_cancel),
    .pix_zone     (pix_zone),
    .sel_zone     (sel_zone),
    .locked       (locked),
    .confirm_pulse(confirm_pulse),
    .highlight    (highlight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    int         h;
    int         v;
    logic [3:0] btn;
    logic [1:0] pz;
    logic [1:0] sz;
    logic       lk;
    logic       cp;
    logic       hl;
  } vec_t;

  localparam logic [3:0] N = 4'b0001;
  localparam logic [3:0] P = 4'b0010;
  localparam logic [3:0] O = 4'b0100;
  localparam logic [3:0] C = 4'b1000;

  int n_vec;
  int n_bad;

  // reference model state
  int   m_sel, m_pix, m_cnt;
  logic m_locked, m_pulse, m_phase, m_prev00;
  logic [3:0] m_btnq;

  function automatic vec_t mk(
    input logic rst, input int h, input int v, input logic [3:0] b,
    input int pz, input int sz, input logic lk, input logic cp, input logic hl
  );
    vec_t t;
    t.rst = rst; t.h = h; t.v = v; t.btn = b;
    t.pz = 2'(pz); t.sz = 2'(sz); t.lk = lk; t.cp = cp; t.hl = hl;
    return t;
  endfunction

  function automatic int ref_zone(input int h, input int v);
    if (h > HS) return (v > VS) ? 1 : 0;
    return (v > VS) ? 2 : 3;
  endfunction

  task automatic model_step(input logic rst, input int h, input int v,
                            input logic [3:0] b);
    logic [3:0] e;
    int ns;
    logic tk;
    if (rst) begin
      m_sel = 0; m_pix = 0; m_cnt = 0; m_locked = 0; m_pulse = 0;
      m_phase = 1; m_prev00 = 0; m_btnq = 4'hF;
      return;
    end
    e = b & ~m_btnq;
    ns = m_sel;
    m_pulse = 0;
    if (!m_locked) begin
      if (e[2]) begin
        m_locked = 1; m_pulse = 1;
      end else if (e[0] && !e[1]) ns = (m_sel + 1) % 4;
      else if (e[1] && !e[0]) ns = (m_sel + 3) % 4;
    end else if (e[3]) m_locked = 0;
    tk = (h == 0 && v == 0) && !m_prev00;
    if (ns != m_sel) begin
      m_cnt = 0; m_phase = 1;
    end else if (tk) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == BF) begin
        m_cnt = 0; m_phase = ~m_phase;
      end
    end
    m_sel = ns;
    m_pix = ref_zone(h, v);
    m_prev00 = (h == 0 && v == 0);
    m_btnq = b;
  endtask

  function automatic logic [6:0] pack(input int pz, input int sz,
      input logic lk, input logic cp, input logic hl);
    return {2'(pz), 2'(sz), lk, cp, hl};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {pix_zone, sel_zone, locked, confirm_pulse, highlight};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got pz/sz/lk/cp/hl=%b want %b",
               name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input int h, input int v,
                       input logic [3:0] b);
    @(negedge clk);
    reset = rst;
    horizontal = 10'(h);
    vertical = 10'(v);
    {btn_cancel, btn_ok, btn_prev, btn_next} = b;
    @(posedge clk);
    model_step(rst, h, v, b);
    #1;
    check("model", pack(m_pix, m_sel, m_locked, m_pulse,
          (m_pix == m_sel) && (m_locked || m_phase)));
  endtask

  vec_t tbl[$];

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    horizontal = '0;
    vertical = '0;
    {btn_cancel, btn_ok, btn_prev, btn_next} = 4'b0;
    model_step(1'b1, 0, 0, 4'b0);

    tbl.push_back(mk(1, 465, 275, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 465, 275, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 465, 276, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 464, 276, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 464, 275, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 464, 275, P, 3, 3, 0, 0, 1));
    tbl.push_back(mk(0, 464, 275, 0, 3, 3, 0, 0, 1));
    tbl.push_back(mk(0, 464, 275, N, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 464, 275, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 464, 275, P, 3, 3, 0, 0, 1));
    tbl.push_back(mk(0, 464, 275, 0, 3, 3, 0, 0, 1));
    tbl.push_back(mk(0, 464, 275, N|P, 3, 3, 0, 0, 1));
    tbl.push_back(mk(0, 464, 275, 0, 3, 3, 0, 0, 1));
    tbl.push_back(mk(0, 464, 275, P, 3, 2, 0, 0, 0));
    tbl.push_back(mk(0, 464, 276, 0, 2, 2, 0, 0, 1));
    tbl.push_back(mk(0, 464, 276, O|N, 2, 2, 1, 1, 1));
    tbl.push_back(mk(0, 464, 276, 0, 2, 2, 1, 0, 1));
    tbl.push_back(mk(0, 464, 276, N, 2, 2, 1, 0, 1));
    tbl.push_back(mk(0, 464, 276, 0, 2, 2, 1, 0, 1));
    tbl.push_back(mk(0, 464, 276, O, 2, 2, 1, 0, 1));
    tbl.push_back(mk(0, 464, 276, C, 2, 2, 0, 0, 1));
    tbl.push_back(mk(0, 464, 276, 0, 2, 2, 0, 0, 1));
    tbl.push_back(mk(0, 500, 300, P, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 500, 300, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 500, 300, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 500, 300, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 500, 300, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 500, 300, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 500, 300, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 500, 300, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 500, 300, N, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 500, 300, P, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 500, 300, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 500, 300, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 464, 275, P, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 464, 275, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 464, 275, P, 3, 3, 0, 0, 1));
    tbl.push_back(mk(0, 464, 275, 0, 3, 3, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 3, 3, 0, 0, 1));
    tbl.push_back(mk(0, 464, 275, 0, 3, 3, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 3, 0, 0, 0));
    tbl.push_back(mk(0, 464, 275, O, 3, 3, 1, 1, 1));
    tbl.push_back(mk(0, 464, 275, 0, 3, 3, 1, 0, 1));
    tbl.push_back(mk(1, 464, 275, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 464, 275, O, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 464, 275, O, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 464, 275, O, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 464, 275, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 464, 275, O, 3, 0, 1, 1, 0));
    tbl.push_back(mk(0, 464, 275, 0, 3, 0, 1, 0, 0));
    tbl.push_back(mk(0, 464, 275, C, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 464, 275, 0, 3, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].h, tbl[i].v, tbl[i].btn);
      check($sformatf("vec%0d", i),
            pack(tbl[i].pz, tbl[i].sz, tbl[i].lk, tbl[i].cp, tbl[i].hl));
    end

    begin
      logic [3:0] b;
      int h, v, r;
      b = 4'b0;
      for (int i = 0; i < 4000; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 3) begin
          h = 0; v = 0;
        end else if (r < 6) begin
          h = int'($urandom_range(HS - 2, HS + 3));
          v = int'($urandom_range(VS - 2, VS + 3));
        end else begin
          h = int'($urandom_range(0, 1023));
          v = int'($urandom_range(0, 1023));
        end
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, 3) == 0) b[k] = ~b[k];
        drive($urandom_range(0, 299) == 0, h, v, b);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
